// File: rtl/seg_display_scanner_if.sv
// Load-side handshake between the value producer and the seven-segment scanner.
// The producer offers a 16-bit value; the scanner accepts it when ready is high.
interface seg_display_scanner_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;

  modport master (
    output load_valid,
    output load_data,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    output load_ready
  );
endinterface

// File: rtl/seg_display_scanner.sv
// Four-digit time-multiplexed seven-segment driver with a double-buffered value
// that only commits at frame boundaries, plus per-digit blanking and leading-zero suppression.
module seg_display_scanner #(
  parameter int unsigned CLK_DIV        = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  seg_display_scanner_if.slave        load_if,
  input  logic [3:0]                  blank_mask,
  input  logic                        lz_suppress,
  output logic [6:0]                  display_segs,
  output logic [3:0]                  display_anodes,
  output logic                        frame_done
);

  localparam int unsigned     PW        = $clog2(CLK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [6:0]      SEGS_OFF  = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b1111110;
      4'h1:    pat = 7'b0110000;
      4'h2:    pat = 7'b1101101;
      4'h3:    pat = 7'b1111001;
      4'h4:    pat = 7'b0110011;
      4'h5:    pat = 7'b1011011;
      4'h6:    pat = 7'b1011111;
      4'h7:    pat = 7'b1110000;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1111011;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b0011111;
      4'hC:    pat = 7'b1001110;
      4'hD:    pat = 7'b0111101;
      4'hE:    pat = 7'b1001111;
      4'hF:    pat = 7'b1000111;
      default: pat = 7'b0000000;
    endcase
    return pat;
  endfunction

  logic [PW-1:0] presc_q,  presc_d;
  logic [1:0]    idx_q,    idx_d;
  logic [15:0]   active_q, active_d;
  logic [15:0]   shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic [6:0]    segs_q,   segs_d;
  logic [3:0]    anodes_q, anodes_d;
  logic          frame_done_q, frame_done_d;

  logic          tick_s;
  logic          boundary_s;
  logic          xfer_s;
  logic [3:0]    nib_s;
  logic [3:0]    upper_zero_s;
  logic          dark_s;
  logic [6:0]    pat_s;

  // State registers; reset discards any pending shadow and restarts the scan.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= 2'd3;
      active_q     <= 16'h0000;
      shadow_q     <= 16'h0000;
      pending_q    <= 1'b0;
      segs_q       <= SEGS_OFF;
      anodes_q     <= 4'b1111;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      segs_q       <= segs_d;
      anodes_q     <= anodes_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Prescaler, digit scan, commit/handshake and output pattern for the next slot.
  always_comb begin
    presc_d      = presc_q;
    idx_d        = idx_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    segs_d       = segs_q;
    anodes_d     = anodes_q;
    frame_done_d = 1'b0;

    tick_s     = (presc_q == PRESC_MAX);
    boundary_s = tick_s && (idx_q == 2'd3);
    xfer_s     = load_if.load_valid && !pending_q;

    if (tick_s) begin
      presc_d = '0;
      idx_d   = idx_q + 2'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Commit and transfer are mutually exclusive because both depend on pending.
    if (boundary_s && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (xfer_s) begin
      shadow_d  = load_if.load_data;
      pending_d = 1'b1;
    end else begin
      pending_d = pending_q;
    end

    nib_s           = active_d[{idx_d, 2'b00} +: 4];
    upper_zero_s[3] = (active_d[15:12] == 4'h0);
    upper_zero_s[2] = upper_zero_s[3] && (active_d[11:8] == 4'h0);
    upper_zero_s[1] = upper_zero_s[2] && (active_d[7:4] == 4'h0);
    upper_zero_s[0] = 1'b0;
    dark_s          = blank_mask[idx_d] || (lz_suppress && upper_zero_s[idx_d]);
    pat_s           = hex_decode(nib_s);

    if (tick_s) begin
      frame_done_d = boundary_s;
      if (dark_s) begin
        anodes_d = 4'b1111;
        segs_d   = SEGS_OFF;
      end else begin
        anodes_d = ~(4'b0001 << idx_d);
        segs_d   = SEG_ACTIVE_LOW ? ~pat_s : pat_s;
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  assign load_if.load_ready = ~pending_q;
  assign display_segs       = segs_q;
  assign display_anodes     = anodes_q;
  assign frame_done         = frame_done_q;

endmodule

// File: doc/seg_display_scanner.md
Name: seg_display_scanner

Overview:
- Time-multiplexed driver for the 4-digit common-anode seven-segment display on the ALU front panel.
- Accepts a 16-bit value (four hex nibbles) through a valid/ready load handshake and double-buffers it.
- Commits new values only at frame boundaries, so the display never tears.
- Scans one digit per refresh tick, driving `display_anodes` (one-hot, active-low) and `display_segs`, with per-digit blanking and leading-zero suppression.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot; minimum 2.
- SEG_ACTIVE_LOW, 1, 1 = invert segment pattern at output (lit segment = 0); 0 = lit segment = 1.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- load_valid  input  1  load_data is valid
- load_ready  output  1  block can accept load_data
- load_data  input  16  nibble i = digit i; digit 0 is rightmost
- blank_mask  input  4  bit i = 1 forces digit i dark
- lz_suppress  input  1  1 = blank leading zero digits
- display_segs  output  7  bit6 = a … bit0 = g, polarity per SEG_ACTIVE_LOW
- display_anodes  output  4  active-low one-hot; 4'b1110 = digit 0
- frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- **Reset (synchronous, active-high), takes effect at the next clk edge:**
  - prescaler = 0; digit index = 3; active = 16'h0000; shadow cleared; pending = 0.
  - load_ready = 1, display_anodes = 4'b1111, display_segs = all segments off, frame_done = 0.
- **Prescaler:**
  - Counts 0..CLK_DIV-1 and wraps; tick = (prescaler == CLK_DIV-1).
  - The first tick occurs CLK_DIV cycles after reset release.
- **On each tick:**
  - index advances 0→1→2→3→0.
  - display_anodes and display_segs are registered for the new index on the same edge.
  - Anode and segment changes are always aligned; there is no intermediate state.
- **Frame boundary = tick where index goes 3→0:**
  - frame_done = 1 for that one cycle.
  - If pending = 1: active ← shadow and pending ← 0 on that edge. Digit 0 of the new frame already shows the committed value.
- **Handshake:**
  - Transfer occurs when load_valid && load_ready.
  - On transfer: shadow ← load_data, pending ← 1.
  - load_ready = !pending (registered). It drops the cycle after a transfer and rises the cycle after a commit.
  - load_data is ignored while load_ready = 0.
  - A transfer on a frame-boundary cycle with pending = 0 commits at the NEXT frame boundary.
- **Decode, active-high pattern before polarity is applied:**
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- **Digit i is dark if either condition holds:**
  - blank_mask[i] = 1, or
  - lz_suppress = 1 and active nibbles i..3 are all zero and i ≠ 0. Digit 0 is never zero-suppressed.
- **Dark digit handling:**
  - anodes = 4'b1111 and segs = all off for that slot.
  - Slot duration is unchanged.
  - blank_mask and lz_suppress are sampled at the tick.
- **Polarity:** output = SEG_ACTIVE_LOW ? ~pattern : pattern.
- **Reset mid-frame:** any pending shadow is discarded and scanning restarts from the reset state.

Test Plan:
1. **Scan timing:** CLK_DIV=4, reset, no load.
   - Anodes 1111 for 4 cycles after release.
   - Then 1110, 1101, 1011, 0111 for 4 cycles each, repeating.
   - segs = 7'b0000001 (a "0" in active-low) on every slot; frame_done pulses every 16 cycles, coincident with 1110.
2. **Load commit:** load 16'h1234 while digit 1 is displayed.
   - load_ready low from the next cycle.
   - Digits keep showing 0 until the frame boundary.
   - Then digits 0..3 show 4, 3, 2, 1 (active-low 1001100, 0000110, 0010010, 1001111).
   - load_ready high the cycle after commit.
3. **Hex decode:** load 16'hFEDC, then 16'hBA98, and so on, covering all 16 nibble values; each segment pattern matches the decode table, inverted.
4. **Blank mask:** blank_mask=4'b0100, value 16'h1234 → the digit-2 slot shows anodes 1111 and segs 1111111 for 4 cycles; other digits unaffected.
5. **Leading-zero suppression:** lz_suppress=1.
   - 16'h0005 → digits 3..1 dark, digit 0 shows 5.
   - 16'h0000 → only digit 0 lit, showing 0.
   - 16'h0105 → only digit 3 dark.
6. **Reset mid-operation:** accept 16'hABCD (pending), assert reset for 1 cycle before the frame boundary → anodes 1111, load_ready=1, and digits show 0000 after the scan resumes; ABCD never appears.
